// File: rtl/mp_alu_seq_pkg.sv
// Shared types for the core ALU and the multi-precision sequencer.
//   opcode_t      : ALU operation select (op_nop is the all-zero idle opcode)
//   ctl_t         : ALU mask. S = sign fill for rotate, NB = invert arg2
//                   (subtract form), C = take carry-in from flags
//   flags_t       : ALU flags C/Z/S/V
//   mpseq_state_t : sequencer FSM state
//   is_sub()      : the one place that decodes the subtract-form mask
package mp_alu_seq_pkg;

    typedef enum logic [2:0] {
        op_nop = 3'd0,
        op_add = 3'd1,
        op_and = 3'd2,
        op_or  = 3'd3,
        op_xor = 3'd4,
        op_rr  = 3'd5
    } opcode_t;

    typedef struct packed {
        logic S;
        logic NB;
        logic C;
    } ctl_t;

    typedef struct packed {
        logic C;
        logic Z;
        logic S;
        logic V;
    } flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mpseq_state_t;

    // Subtract form: arg2 is inverted and the ALU treats flag C as a borrow.
    function automatic logic is_sub(input ctl_t m);
        return m.NB;
    endfunction

endpackage

// File: rtl/mp_alu_seq_if.sv
// Bus between the control unit / data store / ALU and the sequencer.
//   cmd_*     : command handshake and fields
//   rd_*      : combinational data-store reads, wr_* : store write port
//   alu_*     : ALU drive and result
//   done      : completion pulse, flags_out : flags of the whole result
// Modports: slave = sequencer, master = everything around it.
interface mp_alu_seq_if
    import mp_alu_seq_pkg::*;
#(
    parameter int width      = 4,
    parameter int max_words  = 8,
    parameter int addr_width = 4
) ();
    localparam int len_w = $clog2(max_words);

    logic                  cmd_valid;
    logic                  cmd_ready;
    opcode_t               cmd_op;
    ctl_t                  cmd_bmask;
    flags_t                cmd_f;
    logic [len_w-1:0]      cmd_len;
    logic [addr_width-1:0] cmd_a_addr;
    logic [addr_width-1:0] cmd_b_addr;
    logic [addr_width-1:0] cmd_d_addr;

    logic [addr_width-1:0] rd_a_addr;
    logic [addr_width-1:0] rd_b_addr;
    logic [width-1:0]      rd_a_data;
    logic [width-1:0]      rd_b_data;

    logic                  wr_en;
    logic [addr_width-1:0] wr_addr;
    logic [width-1:0]      wr_data;

    opcode_t               alu_opcode;
    ctl_t                  alu_bmask;
    logic [width-1:0]      alu_arg1;
    logic [width-1:0]      alu_arg2;
    flags_t                alu_f;
    logic [width-1:0]      alu_dout;
    flags_t                alu_fout;

    logic                  done;
    flags_t                flags_out;

    modport slave (
        input  cmd_valid, cmd_op, cmd_bmask, cmd_f, cmd_len,
               cmd_a_addr, cmd_b_addr, cmd_d_addr,
               rd_a_data, rd_b_data, alu_dout, alu_fout,
        output cmd_ready, rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data,
               alu_opcode, alu_bmask, alu_arg1, alu_arg2, alu_f,
               done, flags_out
    );

    modport master (
        output cmd_valid, cmd_op, cmd_bmask, cmd_f, cmd_len,
               cmd_a_addr, cmd_b_addr, cmd_d_addr,
               rd_a_data, rd_b_data, alu_dout, alu_fout,
        input  cmd_ready, rd_a_addr, rd_b_addr, wr_en, wr_addr, wr_data,
               alu_opcode, alu_bmask, alu_arg1, alu_arg2, alu_f,
               done, flags_out
    );

endinterface

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: takes one N-word command, streams the operand
// words through the single-word ALU one per cycle (op_rr MSW-first, all
// others LSW-first), chains the carry between words and writes each result
// word back to the store.
//   clk, rst_n : clock, async active-low reset
//   bus        : mp_alu_seq_if.slave (command, store, ALU, done/flags_out)
module mp_alu_seq
    import mp_alu_seq_pkg::*;
#(
    parameter int width      = 4,
    parameter int max_words  = 8,
    parameter int addr_width = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mp_alu_seq_if.slave bus
);
    localparam int len_w = $clog2(max_words);

    mpseq_state_t          state;
    opcode_t               op_q;
    ctl_t                  bmask_q;
    logic                  cin_q;
    logic [len_w-1:0]      len_q;
    logic [len_w-1:0]      idx;
    logic [addr_width-1:0] a_base;
    logic [addr_width-1:0] b_base;
    logic [addr_width-1:0] d_base;
    logic                  first_q;
    logic                  c_reg;
    logic                  z_acc;
    logic                  s_msw;
    logic                  v_msw;
    logic                  done_q;
    flags_t                flags_q;

    logic                  run;
    logic                  down;
    logic                  last;
    logic                  msw;
    logic [addr_width-1:0] idx_ext;
    ctl_t                  word_bmask;
    logic [width-1:0]      arg1;
    logic [width-1:0]      arg2;

    assign run     = (state == RUN);
    assign down    = (op_q == op_rr);
    assign last    = down ? (idx == '0) : (idx == len_q);
    // The MSW is the first word for op_rr and the last word otherwise.
    assign msw     = down ? first_q : last;
    assign idx_ext = addr_width'(idx);
    assign arg1    = bus.rd_a_data;
    assign arg2    = bus.rd_b_data;

    // After the first word the carry always comes from the chain, and the
    // rotate sign fill only belongs on the MSW.
    always_comb begin
        word_bmask = bmask_q;
        if (!first_q) begin
            word_bmask.C = 1'b1;
            word_bmask.S = 1'b0;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rd_a_addr = a_base + idx_ext;
    assign bus.rd_b_addr = b_base + idx_ext;
    assign bus.wr_en     = run;
    assign bus.wr_addr   = d_base + idx_ext;
    assign bus.wr_data   = bus.alu_dout;
    assign bus.done      = done_q;
    assign bus.flags_out = flags_q;

    always_comb begin
        bus.alu_opcode = op_nop;
        bus.alu_bmask  = '0;
        bus.alu_arg1   = '0;
        bus.alu_arg2   = '0;
        bus.alu_f      = '0;
        if (run) begin
            bus.alu_opcode = op_q;
            bus.alu_bmask  = word_bmask;
            bus.alu_arg1   = arg1;
            bus.alu_arg2   = arg2;
            if (first_q)
                bus.alu_f.C = cin_q;
            else
                // The ALU inverts C in subtract form, so pre-invert the
                // chained carry to hand it the right borrow.
                bus.alu_f.C = is_sub(bmask_q) ? ~c_reg : c_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= op_nop;
            bmask_q <= '0;
            cin_q   <= 1'b0;
            len_q   <= '0;
            idx     <= '0;
            a_base  <= '0;
            b_base  <= '0;
            d_base  <= '0;
            first_q <= 1'b0;
            c_reg   <= 1'b0;
            z_acc   <= 1'b0;
            s_msw   <= 1'b0;
            v_msw   <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state   <= RUN;
                        op_q    <= bus.cmd_op;
                        bmask_q <= bus.cmd_bmask;
                        cin_q   <= bus.cmd_f.C;
                        len_q   <= bus.cmd_len;
                        a_base  <= bus.cmd_a_addr;
                        b_base  <= bus.cmd_b_addr;
                        d_base  <= bus.cmd_d_addr;
                        idx     <= (bus.cmd_op == op_rr) ? bus.cmd_len : '0;
                        first_q <= 1'b1;
                        z_acc   <= 1'b1;
                    end
                end
                RUN: begin
                    first_q <= 1'b0;
                    c_reg   <= bus.alu_fout.C;
                    z_acc   <= z_acc & bus.alu_fout.Z;
                    if (msw) begin
                        s_msw <= bus.alu_fout.S;
                        v_msw <= bus.alu_fout.V;
                    end
                    if (last) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        flags_q.C <= bus.alu_fout.C;
                        flags_q.Z <= z_acc & bus.alu_fout.Z;
                        flags_q.S <= msw ? bus.alu_fout.S : s_msw;
                        flags_q.V <= msw ? bus.alu_fout.V : v_msw;
                    end else begin
                        idx <= down ? (idx - len_w'(1)) : (idx + len_w'(1));
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq: word-level ALU and data store around the DUT,
// whole-operand arithmetic reference, directed cases plus random commands.
module tb_mp_alu_seq;
    import mp_alu_seq_pkg::*;

    localparam int W  = 4;
    localparam int MW = 8;
    localparam int AW = 4;
    localparam int LW = $clog2(MW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mp_alu_seq_if #(.width(W), .max_words(MW), .addr_width(AW)) bus ();

    mp_alu_seq #(.width(W), .max_words(MW), .addr_width(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data store: combinational read, write at the clock edge.
    logic [W-1:0] mem [0:(1<<AW)-1];
    assign bus.rd_a_data = mem[bus.rd_a_addr];
    assign bus.rd_b_data = mem[bus.rd_b_addr];
    always @(posedge clk) if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

    // Single-word ALU.
    logic [W-1:0] alu_b2;
    logic         alu_cin;
    logic         alu_fill;
    logic [W:0]   alu_sum;
    always_comb begin
        alu_b2   = is_sub(bus.alu_bmask) ? ~bus.alu_arg2 : bus.alu_arg2;
        alu_cin  = bus.alu_bmask.C ? (is_sub(bus.alu_bmask) ? ~bus.alu_f.C : bus.alu_f.C)
                                   : is_sub(bus.alu_bmask);
        alu_fill = bus.alu_bmask.S ? bus.alu_arg1[W-1] : (bus.alu_bmask.C & bus.alu_f.C);
        alu_sum  = {1'b0, bus.alu_arg1} + {1'b0, alu_b2} + {{W{1'b0}}, alu_cin};
        bus.alu_dout = '0;
        bus.alu_fout = '0;
        case (bus.alu_opcode)
            op_add: begin
                bus.alu_dout   = alu_sum[W-1:0];
                bus.alu_fout.C = alu_sum[W];
                bus.alu_fout.V = (bus.alu_arg1[W-1] == alu_b2[W-1]) && (alu_sum[W-1] != bus.alu_arg1[W-1]);
            end
            op_and: bus.alu_dout = bus.alu_arg1 & bus.alu_arg2;
            op_or:  bus.alu_dout = bus.alu_arg1 | bus.alu_arg2;
            op_xor: bus.alu_dout = bus.alu_arg1 ^ bus.alu_arg2;
            op_rr: begin
                bus.alu_dout   = {alu_fill, bus.alu_arg1[W-1:1]};
                bus.alu_fout.C = bus.alu_arg1[0];
            end
            default: ;
        endcase
        bus.alu_fout.Z = (bus.alu_dout == '0);
        bus.alu_fout.S = bus.alu_dout[W-1];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Whole-operand reference: the N words are one nb-bit number.
    function automatic void ref_model(input opcode_t op, input ctl_t bm, input logic fc, input int n,
                                      input logic [63:0] a_in, input logic [63:0] b_in,
                                      output logic [63:0] d, output flags_t f);
        int          nb;
        logic [63:0] mask, a, b, b2;
        logic [64:0] s;
        logic        cin, fill;
        nb   = n * W;
        mask = (64'd1 << nb) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        d    = '0;
        f    = '0;
        case (op)
            op_add: begin
                b2  = bm.NB ? (~b & mask) : b;
                cin = bm.C ? (bm.NB ? ~fc : fc) : bm.NB;
                s   = {1'b0, a} + {1'b0, b2} + {64'd0, cin};
                d   = s[63:0] & mask;
                f.C = s[nb];
                f.V = (a[nb-1] == b2[nb-1]) && (d[nb-1] != a[nb-1]);
            end
            op_and: d = a & b;
            op_or:  d = a | b;
            op_xor: d = a ^ b;
            op_rr: begin
                fill = bm.S ? a[nb-1] : (bm.C & fc);
                d    = (a >> 1) | ({63'd0, fill} << (nb - 1));
                f.C  = a[0];
            end
            default: ;
        endcase
        f.Z = (d == 64'd0);
        f.S = d[nb-1];
    endfunction

    // Runs one command from IDLE; returns at the negedge of the cycle after
    // done (IDLE again). hold leaves cmd_valid asserted for a follow-up.
    task automatic do_cmd(input opcode_t op, input ctl_t bm, input logic fc, input int n,
                          input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] db,
                          input logic [63:0] a, input logic [63:0] b, input bit load, input bit hold,
                          output logic [63:0] res);
        logic [63:0]   ed, got;
        flags_t        ef;
        logic [AW-1:0] wa;
        if (load) begin
            for (int i = 0; i < n; i++) begin
                mem[AW'(int'(ab) + i)] <= a[i*W +: W];
                mem[AW'(int'(bb) + i)] <= b[i*W +: W];
            end
        end
        ref_model(op, bm, fc, n, a, b, ed, ef);
        res            = ed;
        bus.cmd_op     = op;
        bus.cmd_bmask  = bm;
        bus.cmd_f      = '0;
        bus.cmd_f.C    = fc;
        bus.cmd_len    = LW'(n - 1);
        bus.cmd_a_addr = ab;
        bus.cmd_b_addr = bb;
        bus.cmd_d_addr = db;
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= n + 1; cyc++) begin
            @(negedge clk);
            if (cyc <= n) begin
                wa = (op == op_rr) ? AW'(int'(db) + n - cyc) : AW'(int'(db) + cyc - 1);
                chk("wr_en_run", bus.wr_en, 1);
                chk("wr_addr", bus.wr_addr, wa);
                chk("ready_run", bus.cmd_ready, 0);
                chk("done_run", bus.done, 0);
            end else begin
                chk("done", bus.done, 1);
                chk("wr_en_done", bus.wr_en, 0);
                chk("ready_done", bus.cmd_ready, 0);
                chk("alu_op_done", bus.alu_opcode, op_nop);
                chk("alu_arg1_done", bus.alu_arg1, 0);
                chk("flags", bus.flags_out, ef);
            end
        end
        @(negedge clk);
        chk("ready_idle", bus.cmd_ready, 1);
        chk("done_idle", bus.done, 0);
        got = '0;
        for (int i = 0; i < n; i++) got[i*W +: W] = mem[AW'(int'(db) + i)];
        chk("data", got, ed);
    endtask

    opcode_t ops [5] = '{op_add, op_and, op_or, op_xor, op_rr};

    initial begin
        logic [63:0]   r, r2;
        opcode_t       op;
        ctl_t          bm;
        int            n;
        logic [AW-1:0] ab, bb, db;

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = op_nop;
        bus.cmd_bmask  = '0;
        bus.cmd_f      = '0;
        bus.cmd_len    = '0;
        bus.cmd_a_addr = '0;
        bus.cmd_b_addr = '0;
        bus.cmd_d_addr = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_flags", bus.flags_out, 0);
        chk("rst_alu_op", bus.alu_opcode, op_nop);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_cmd(op_add, ctl_t'(3'b001), 1'b0, 3, 4'd0, 4'd4, 4'd8, 64'h0FF, 64'h001, 1, 0, r);
        chk("add_const", r, 64'h100);
        do_cmd(op_add, ctl_t'(3'b011), 1'b0, 3, 4'd0, 4'd4, 4'd8, 64'h100, 64'h001, 1, 0, r);
        chk("sub_const", r, 64'h0FF);
        chk("sub_c", bus.flags_out.C, 1);
        do_cmd(op_rr, ctl_t'(3'b100), 1'b0, 2, 4'd2, 4'd6, 4'd10, 64'h80, 64'h0, 1, 0, r);
        chk("rr_const", r, 64'hC0);
        do_cmd(op_xor, ctl_t'(3'b000), 1'b0, 4, 4'd0, 4'd4, 4'd8, 64'h1234, 64'h1234, 1, 0, r);
        chk("xor_z1", bus.flags_out.Z, 1);
        do_cmd(op_xor, ctl_t'(3'b000), 1'b0, 4, 4'd0, 4'd4, 4'd8, 64'h1234, 64'h1230, 1, 0, r);
        chk("xor_z0", bus.flags_out.Z, 0);
        do_cmd(op_add, ctl_t'(3'b001), 1'b1, 1, 4'd15, 4'd3, 4'd7, 64'h9, 64'h7, 1, 0, r);

        // Back-to-back with cmd_valid held: in-place accumulate twice.
        do_cmd(op_add, ctl_t'(3'b001), 1'b0, 3, 4'd1, 4'd9, 4'd1, 64'h3A5, 64'h0C7, 1, 1, r);
        do_cmd(op_add, ctl_t'(3'b001), 1'b0, 3, 4'd1, 4'd9, 4'd1, r, 64'h0C7, 0, 0, r2);
        chk("b2b_const", r2, 64'h533);

        // Reset in the second RUN cycle of a 4-word add.
        for (int i = 0; i < 4; i++) begin
            mem[i]     <= 4'h1;
            mem[4 + i] <= 4'h2;
            mem[8 + i] <= 4'hF;
        end
        bus.cmd_op     = op_add;
        bus.cmd_bmask  = ctl_t'(3'b001);
        bus.cmd_f      = '0;
        bus.cmd_len    = LW'(3);
        bus.cmd_a_addr = 4'd0;
        bus.cmd_b_addr = 4'd4;
        bus.cmd_d_addr = 4'd8;
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 chk("mid_wr_en_pre", bus.wr_en, 1);
        #1 rst_n = 1'b0;
        #1 chk("mid_wr_en_drop", bus.wr_en, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mid_no_done", bus.done, 0);
        end
        chk("mid_ready", bus.cmd_ready, 1);
        chk("mid_flags", bus.flags_out, 0);
        chk("mid_word0", mem[8], 4'h3);
        chk("mid_word1", mem[9], 4'hF);
        chk("mid_word3", mem[11], 4'hF);
        do_cmd(op_add, ctl_t'(3'b001), 1'b0, 4, 4'd0, 4'd4, 4'd8, 64'h1111, 64'h2222, 1, 0, r);

        // Random commands; destination is in-place on A or B.
        for (int t = 0; t < 40; t++) begin
            op = ops[$urandom_range(0, 4)];
            bm = ctl_t'($urandom_range(0, 7));
            if (op == op_rr) bm.NB = 1'b0;
            n  = $urandom_range(1, MW);
            ab = AW'($urandom_range(0, (1 << AW) - 1));
            bb = ab + AW'(8);
            db = $urandom_range(0, 1) ? ab : bb;
            do_cmd(op, bm, 1'($urandom_range(0, 1)), n, ab, bb, db,
                   {$urandom, $urandom}, {$urandom, $urandom}, 1, 0, r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
